ccip_mem_responder: RTL and testbench
=====================================

Name: ccip_mem_responder

Overview:
- Memory-side responder for the CCI-P-style channels that the memcpy DMA engine drives.
- Accepts c0 read requests and c1 write requests, and serves them from an on-chip line memory.
- Returns read-data and write-ack responses carrying the requester's mdata.
- Used as a loopback target for bringing up DMA/AFU logic in simulation and in-fabric self-test, without host memory.

Parameters:
- ADDR_W, 42, width of the cache-line address (t_ccip_clAddr width).
- DEPTH_LOG2, 10, log2 of the number of 512-bit lines in the memory.
- FIFO_DEPTH, 16, entries in each request FIFO; power of 2, at least 8.
- ALM_FULL_SLACK, 8, free entries remaining when almost-full asserts.
- READ_LAT, 2, cycles from read-FIFO pop to c0_rsp_valid; at least 1.

Ports:
- clk in 1: sole clock.
- reset_n in 1: asynchronous, active-low reset.
- c0_req_valid in 1: read request strobe.
- c0_req_addr in ADDR_W: read line address.
- c0_req_mdata in 16: read tag, echoed in the response.
- c0_alm_full out 1: read request channel almost full.
- c1_req_valid in 1: write request strobe.
- c1_req_addr in ADDR_W: write line address.
- c1_req_data in 512: write data.
- c1_req_mdata in 16: write tag, echoed in the response.
- c1_alm_full out 1: write request channel almost full.
- c0_rsp_valid out 1: read response strobe.
- c0_rsp_data out 512: read data.
- c0_rsp_mdata out 16: echoed read tag.
- c1_rsp_valid out 1: write acknowledge strobe.
- c1_rsp_mdata out 16: echoed write tag.
- rd_count out 32: read responses issued.
- wr_count out 32: write acks issued.
- overflow_err out 1: sticky flag, a request arrived while its FIFO was full.

Behaviour:
- Reset is asynchronous and active-low on reset_n, with clock clk.
- While reset_n=0, all outputs are 0:
  - valids, data, mdata, alm_full, counters and overflow_err;
  - FIFOs are emptied;
  - read pipeline stages are invalidated.
- Memory contents are not reset.
- Reset asserted mid-operation:
  - all queued and in-flight requests are discarded, with no responses;
  - a memory write already popped in that cycle may or may not land.
- Request acceptance:
  - a valid request is pushed into its channel FIFO in the same cycle;
  - there is no backpressure handshake; the requester must honour alm_full.
- Almost-full: cX_alm_full = (occupancy >= FIFO_DEPTH - ALM_FULL_SLACK), registered from the previous cycle's occupancy.
  - The requester may issue up to ALM_FULL_SLACK-1 more requests after assertion without loss.
- Overflow: a request while the FIFO is full is dropped and sets overflow_err=1.
  - overflow_err stays set until reset.
  - A push and a pop in the same cycle on a full FIFO is not an overflow.
- Addressing: memory index = addr[DEPTH_LOG2-1:0]; upper bits are ignored, so addresses wrap.
- Write path, per cycle when the write FIFO is non-empty:
  - pop one entry and write the line;
  - exactly 1 cycle later, c1_rsp_valid=1 with that entry's mdata.
- Read path, per cycle when the read FIFO is non-empty:
  - pop one entry;
  - c0_rsp_valid=1 exactly READ_LAT cycles later, with the data and mdata.
- Throughput: one read and one write per cycle, concurrently.
- Ordering: responses stay in order within each channel; there is no ordering between channels.
- Read and write popped in the same cycle to the same index: the read returns the OLD data (read-first). A read popped any later cycle sees the new data.
- Empty FIFO means no pop and no response that cycle.
- Response valids are single-cycle pulses; data and mdata are don't-care when valid=0.
- Counters: rd_count increments on each c0_rsp_valid and wr_count on each c1_rsp_valid. Both wrap modulo 2^32.
- Total latency from an idle state:
  - write request to c1_rsp_valid is 2 cycles (push, pop+write, ack);
  - read request to c0_rsp_valid is READ_LAT+1 cycles.

Test Plan:
- Basic write then read: write addr 0x5, data 0xA5..A5, mdata 0x0011.
  - c1_rsp_valid 2 cycles later with mdata 0x0011.
  - A later read of addr 0x5 with mdata 0x0022 returns 0xA5..A5 and mdata 0x0022 after READ_LAT+1=3 cycles.
  - wr_count=1, rd_count=1.
- Same-cycle same-address hazard: preload addr 3 = X, then pop a read and a write of Y to addr 3 together.
  - The read returns X.
  - A following read returns Y.
- Almost-full/slack: hold c0_req_valid for 20 cycles with the read pop path stalled (bench wrapper drives FIFO pop inhibit via force).
  - c0_alm_full rises once occupancy reaches 8.
  - 7 further requests are accepted and overflow_err stays 0.
  - Filling to 16 and sending a 17th sets overflow_err=1; the 17th is never answered.
- Streaming: 64 back-to-back reads and 64 back-to-back writes, concurrent.
  - 64 responses on each channel, at 1 per cycle.
  - mdata order preserved on each channel.
  - rd_count=wr_count=64.
- Address wrap: write addr (1<<DEPTH_LOG2)+7 with data D, then read addr 7.
  - Returns D.
- Reset mid-burst: 10 reads queued, then reset_n pulsed low for 1 cycle asynchronously (off-edge).
  - All outputs go to 0 immediately.
  - No c0_rsp_valid after release.
  - Memory contents written before reset remain readable.

Source files
------------

// File: rtl/ccip_mem_responder_if.sv
// Request/response channel bundle between a CCI-P-style requester and the line-memory responder.
interface ccip_mem_responder_if #(
  parameter int ADDR_W = 42
);
  logic              c0_req_valid;
  logic [ADDR_W-1:0] c0_req_addr;
  logic [15:0]       c0_req_mdata;
  logic              c0_alm_full;
  logic              c1_req_valid;
  logic [ADDR_W-1:0] c1_req_addr;
  logic [511:0]      c1_req_data;
  logic [15:0]       c1_req_mdata;
  logic              c1_alm_full;
  logic              c0_rsp_valid;
  logic [511:0]      c0_rsp_data;
  logic [15:0]       c0_rsp_mdata;
  logic              c1_rsp_valid;
  logic [15:0]       c1_rsp_mdata;

  modport master (
    output c0_req_valid, c0_req_addr, c0_req_mdata,
    output c1_req_valid, c1_req_addr, c1_req_data, c1_req_mdata,
    input  c0_alm_full, c1_alm_full,
    input  c0_rsp_valid, c0_rsp_data, c0_rsp_mdata,
    input  c1_rsp_valid, c1_rsp_mdata
  );

  modport slave (
    input  c0_req_valid, c0_req_addr, c0_req_mdata,
    input  c1_req_valid, c1_req_addr, c1_req_data, c1_req_mdata,
    output c0_alm_full, c1_alm_full,
    output c0_rsp_valid, c0_rsp_data, c0_rsp_mdata,
    output c1_rsp_valid, c1_rsp_mdata
  );
endinterface

// File: rtl/ccip_mem_responder.sv
// Loopback memory target: queues c0 reads / c1 writes in FIFOs and serves them from an on-chip line memory.
module ccip_mem_responder #(
  parameter int ADDR_W         = 42,
  parameter int DEPTH_LOG2     = 10,
  parameter int FIFO_DEPTH     = 16,
  parameter int ALM_FULL_SLACK = 8,
  parameter int READ_LAT       = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  ccip_mem_responder_if.slave bus,
  output logic [31:0]         rd_count,
  output logic [31:0]         wr_count,
  output logic                overflow_err
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ALM_LVL  = CNT_W'(FIFO_DEPTH - ALM_FULL_SLACK);

  logic [511:0] mem [2**DEPTH_LOG2];

  // Upper address bits are intentionally ignored so addresses alias onto the memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.c0_req_addr[ADDR_W-1:DEPTH_LOG2], bus.c1_req_addr[ADDR_W-1:DEPTH_LOG2]};

  // Read-pop inhibit; tied off in hardware, available for stalling the read path in simulation.
  logic rd_hold;
  assign rd_hold = 1'b0;

  logic [DEPTH_LOG2-1:0] rq_idx   [FIFO_DEPTH];
  logic [15:0]           rq_mdata [FIFO_DEPTH];
  logic [PTR_W-1:0]      rq_wp, rq_rp;
  logic [CNT_W-1:0]      rq_cnt;
  logic                  rq_push, rq_pop, rq_ovf, rq_alm;

  logic [DEPTH_LOG2-1:0] wq_idx   [FIFO_DEPTH];
  logic [511:0]          wq_data  [FIFO_DEPTH];
  logic [15:0]           wq_mdata [FIFO_DEPTH];
  logic [PTR_W-1:0]      wq_wp, wq_rp;
  logic [CNT_W-1:0]      wq_cnt;
  logic                  wq_push, wq_pop, wq_ovf, wq_alm;

  // A full FIFO that pops this cycle can still take a push.
  always_comb begin
    rq_pop  = (rq_cnt != '0) && !rd_hold;
    rq_push = bus.c0_req_valid && ((rq_cnt != FULL_LVL) || rq_pop);
    rq_ovf  = bus.c0_req_valid && !rq_push;
    wq_pop  = (wq_cnt != '0);
    wq_push = bus.c1_req_valid && ((wq_cnt != FULL_LVL) || wq_pop);
    wq_ovf  = bus.c1_req_valid && !wq_push;
  end

  always_ff @(posedge clk) begin
    if (rq_push) begin
      rq_idx[rq_wp]   <= bus.c0_req_addr[DEPTH_LOG2-1:0];
      rq_mdata[rq_wp] <= bus.c0_req_mdata;
    end
    if (wq_push) begin
      wq_idx[wq_wp]   <= bus.c1_req_addr[DEPTH_LOG2-1:0];
      wq_data[wq_wp]  <= bus.c1_req_data;
      wq_mdata[wq_wp] <= bus.c1_req_mdata;
    end
    if (wq_pop)
      mem[wq_idx[wq_rp]] <= wq_data[wq_rp];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rq_wp        <= '0;
      rq_rp        <= '0;
      rq_cnt       <= '0;
      rq_alm       <= 1'b0;
      wq_wp        <= '0;
      wq_rp        <= '0;
      wq_cnt       <= '0;
      wq_alm       <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (rq_push) rq_wp <= rq_wp + 1'b1;
      if (rq_pop)  rq_rp <= rq_rp + 1'b1;
      rq_cnt <= rq_cnt + CNT_W'(rq_push) - CNT_W'(rq_pop);
      rq_alm <= (rq_cnt >= ALM_LVL);
      if (wq_push) wq_wp <= wq_wp + 1'b1;
      if (wq_pop)  wq_rp <= wq_rp + 1'b1;
      wq_cnt <= wq_cnt + CNT_W'(wq_push) - CNT_W'(wq_pop);
      wq_alm <= (wq_cnt >= ALM_LVL);
      overflow_err <= overflow_err | rq_ovf | wq_ovf;
    end
  end

  assign bus.c0_alm_full = rq_alm;
  assign bus.c1_alm_full = wq_alm;

  // Stage 0 reads memory alongside the write-path update, which gives read-first on a same-index collision.
  logic         rp_vld  [READ_LAT];
  logic [15:0]  rp_mdata[READ_LAT];
  logic [511:0] rp_data [READ_LAT];
  logic         rd_next;

  if (READ_LAT == 1) begin : g_lat1
    assign rd_next = rq_pop;
  end else begin : g_latn
    assign rd_next = rp_vld[READ_LAT-2];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < READ_LAT; i++) begin
        rp_vld[i]   <= 1'b0;
        rp_mdata[i] <= '0;
        rp_data[i]  <= '0;
      end
      rd_count <= '0;
    end else begin
      rp_vld[0]   <= rq_pop;
      rp_mdata[0] <= rq_mdata[rq_rp];
      rp_data[0]  <= mem[rq_idx[rq_rp]];
      for (int i = 1; i < READ_LAT; i++) begin
        rp_vld[i]   <= rp_vld[i-1];
        rp_mdata[i] <= rp_mdata[i-1];
        rp_data[i]  <= rp_data[i-1];
      end
      rd_count <= rd_count + 32'(rd_next);
    end
  end

  assign bus.c0_rsp_valid = rp_vld[READ_LAT-1];
  assign bus.c0_rsp_mdata = rp_mdata[READ_LAT-1];
  assign bus.c0_rsp_data  = rp_data[READ_LAT-1];

  logic        ack_vld;
  logic [15:0] ack_mdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_vld   <= 1'b0;
      ack_mdata <= '0;
      wr_count  <= '0;
    end else begin
      ack_vld   <= wq_pop;
      ack_mdata <= wq_mdata[wq_rp];
      wr_count  <= wr_count + 32'(wq_pop);
    end
  end

  assign bus.c1_rsp_valid = ack_vld;
  assign bus.c1_rsp_mdata = ack_mdata;
endmodule

// File: tb/tb_ccip_mem_responder.sv
// Directed bench for ccip_mem_responder: vector table of single transactions plus hand-written corner sequences.
module tb_ccip_mem_responder;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] rd_count, wr_count;
  logic        overflow_err;
  int          total = 0;
  int          bad = 0;

  ccip_mem_responder_if #(.ADDR_W(42)) bus ();

  ccip_mem_responder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .rd_count     (rd_count),
    .wr_count     (wr_count),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           wr;
    logic [41:0]  addr;
    logic [511:0] data;
    logic [15:0]  mdata;
  } vec_t;

  localparam logic [511:0] PAT_A5 = {64{8'hA5}};
  localparam logic [511:0] PAT_D  = {16{32'hDEAD_0007}};
  localparam logic [511:0] PAT_X  = {16{32'h1234_5678}};
  localparam logic [511:0] PAT_Y  = {16{32'h9ABC_DEF0}};
  localparam logic [511:0] PAT_P  = {8{64'h0F0F_1111_2222_3333}};

  vec_t vecs[8];

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic idle_bus();
    bus.c0_req_valid = 1'b0;
    bus.c1_req_valid = 1'b0;
  endtask

  // Issue one request at a negedge and check latency, tag and (for reads) data.
  task automatic do_txn(input vec_t v, input string tag);
    int seen;
    logic [15:0]  m;
    logic [511:0] d;
    seen = 0; m = '0; d = '0;
    if (v.wr) begin
      bus.c1_req_valid = 1'b1; bus.c1_req_addr = v.addr;
      bus.c1_req_data = v.data; bus.c1_req_mdata = v.mdata;
    end else begin
      bus.c0_req_valid = 1'b1; bus.c0_req_addr = v.addr; bus.c0_req_mdata = v.mdata;
    end
    @(negedge clk);
    idle_bus();
    for (int k = 1; k <= 8; k++) begin
      if (seen == 0 && v.wr && bus.c1_rsp_valid) begin seen = k; m = bus.c1_rsp_mdata; end
      if (seen == 0 && !v.wr && bus.c0_rsp_valid) begin seen = k; m = bus.c0_rsp_mdata; d = bus.c0_rsp_data; end
      @(negedge clk);
    end
    check({tag, "_lat"}, 512'(seen), v.wr ? 512'd2 : 512'd3);
    check({tag, "_mdata"}, 512'(m), 512'(v.mdata));
    if (!v.wr) check({tag, "_data"}, d, v.data);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nr, nw, errs, seen, lat;
    logic [15:0]  rmd [80];
    logic [15:0]  wmd [80];
    int           rcyc[80];
    int           wcyc[80];
    logic [511:0] d;

    vecs[0] = '{1'b1, 42'h5,                PAT_A5, 16'h0011};
    vecs[1] = '{1'b0, 42'h5,                PAT_A5, 16'h0022};
    vecs[2] = '{1'b1, 42'h400 + 42'd7,      PAT_D,  16'h0033};
    vecs[3] = '{1'b0, 42'h7,                PAT_D,  16'h0044};
    vecs[4] = '{1'b1, 42'h3,                PAT_X,  16'h0055};
    vecs[5] = '{1'b0, 42'h3,                PAT_X,  16'h0056};
    vecs[6] = '{1'b1, 42'h3FF,              PAT_P,  16'hBEEF};
    vecs[7] = '{1'b0, 42'h3_0000_0000 + 42'h3FF, PAT_P, 16'hCAFE};

    idle_bus();
    bus.c0_req_addr = '0; bus.c0_req_mdata = '0;
    bus.c1_req_addr = '0; bus.c1_req_data = '0; bus.c1_req_mdata = '0;
    #1;
    check("rst_c0_valid", 512'(bus.c0_rsp_valid), 512'd0);
    check("rst_c0_data", bus.c0_rsp_data, 512'd0);
    check("rst_alm", 512'({bus.c0_alm_full, bus.c1_alm_full}), 512'd0);
    check("rst_counts", 512'({rd_count, wr_count}), 512'd0);
    check("rst_ovf", 512'(overflow_err), 512'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) do_txn(vecs[i], $sformatf("vec%0d", i));
    check("table_wr_count", 512'(wr_count), 512'd4);
    check("table_rd_count", 512'(rd_count), 512'd4);

    // Read and write of addr 3 pushed together, so they pop together: read sees old X.
    bus.c0_req_valid = 1'b1; bus.c0_req_addr = 42'h3; bus.c0_req_mdata = 16'h0066;
    bus.c1_req_valid = 1'b1; bus.c1_req_addr = 42'h3; bus.c1_req_data = PAT_Y; bus.c1_req_mdata = 16'h0077;
    @(negedge clk);
    idle_bus();
    seen = 0; d = '0;
    for (int k = 1; k <= 8; k++) begin
      if (seen == 0 && bus.c0_rsp_valid) begin seen = k; d = bus.c0_rsp_data; end
      @(negedge clk);
    end
    check("hazard_lat", 512'(seen), 512'd3);
    check("hazard_old_data", d, PAT_X);
    do_txn('{1'b0, 42'h3, PAT_Y, 16'h0088}, "hazard_new");

    // Streaming: 64 reads and 64 writes back to back, concurrently.
    pulse_reset();
    nr = 0; nw = 0;
    for (int c = 0; c < 80; c++) begin
      if (bus.c0_rsp_valid && nr < 80) begin rmd[nr] = bus.c0_rsp_mdata; rcyc[nr] = c; nr++; end
      if (bus.c1_rsp_valid && nw < 80) begin wmd[nw] = bus.c1_rsp_mdata; wcyc[nw] = c; nw++; end
      if (c < 64) begin
        bus.c0_req_valid = 1'b1; bus.c0_req_addr = 42'h100 + 42'(c); bus.c0_req_mdata = 16'(c);
        bus.c1_req_valid = 1'b1; bus.c1_req_addr = 42'h200 + 42'(c);
        bus.c1_req_data = {16{32'(c)}}; bus.c1_req_mdata = 16'h200 + 16'(c);
      end else idle_bus();
      @(negedge clk);
    end
    check("stream_rd_n", 512'(nr), 512'd64);
    check("stream_wr_n", 512'(nw), 512'd64);
    errs = 0;
    for (int k = 0; k < 64 && k < nr; k++)
      if (rmd[k] !== 16'(k) || rcyc[k] != 3 + k) errs++;
    check("stream_rd_order", 512'(errs), 512'd0);
    errs = 0;
    for (int k = 0; k < 64 && k < nw; k++)
      if (wmd[k] !== 16'h200 + 16'(k) || wcyc[k] != 2 + k) errs++;
    check("stream_wr_order", 512'(errs), 512'd0);
    check("stream_rd_count", 512'(rd_count), 512'd64);
    check("stream_wr_count", 512'(wr_count), 512'd64);
    check("stream_ovf", 512'(overflow_err), 512'd0);

    // Almost-full and overflow with the read pop path stalled.
    force dut.rd_hold = 1'b1;
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      bus.c0_req_valid = 1'b1; bus.c0_req_addr = 42'h5; bus.c0_req_mdata = 16'h100 + 16'(i);
      @(negedge clk);
      total++;
      if (bus.c0_alm_full !== (i >= 8)) begin
        bad++;
        $display("FAIL alm_full_step%0d got=%0b want=%0b", i, bus.c0_alm_full, (i >= 8));
      end
      total++;
      if (overflow_err !== (i >= 16)) begin
        bad++;
        $display("FAIL ovf_step%0d got=%0b want=%0b", i, overflow_err, (i >= 16));
      end
    end
    idle_bus();
    release dut.rd_hold;
    nr = 0; errs = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.c0_rsp_valid) begin
        if (bus.c0_rsp_mdata !== 16'h100 + 16'(nr) || bus.c0_rsp_data !== PAT_A5) errs++;
        nr++;
      end
      @(negedge clk);
    end
    check("drain_n", 512'(nr), 512'd16);
    check("drain_order", 512'(errs), 512'd0);
    check("drain_ovf_sticky", 512'(overflow_err), 512'd1);

    // Reset mid-burst: 10 reads queued, asynchronous reset between edges.
    force dut.rd_hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.c0_req_valid = 1'b1; bus.c0_req_addr = 42'h5; bus.c0_req_mdata = 16'h300 + 16'(i);
      @(negedge clk);
    end
    idle_bus();
    @(negedge clk);
    check("pre_rst_alm", 512'(bus.c0_alm_full), 512'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_alm", 512'({bus.c0_alm_full, bus.c1_alm_full}), 512'd0);
    check("arst_counts", 512'({rd_count, wr_count}), 512'd0);
    check("arst_ovf", 512'(overflow_err), 512'd0);
    check("arst_rsp", 512'({bus.c0_rsp_valid, bus.c1_rsp_valid, bus.c0_rsp_mdata, bus.c1_rsp_mdata}), 512'd0);
    check("arst_rdata", bus.c0_rsp_data, 512'd0);
    release dut.rd_hold;
    #9 reset_n = 1'b1;
    @(negedge clk);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.c0_rsp_valid) seen++;
      @(negedge clk);
    end
    check("post_rst_no_rsp", 512'(seen), 512'd0);
    do_txn('{1'b0, 42'h5, PAT_A5, 16'h0099}, "post_rst_mem5");
    do_txn('{1'b0, 42'h3, PAT_Y,  16'h009A}, "post_rst_mem3");
    check("post_rst_rd_count", 512'(rd_count), 512'd2);
    lat = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
